// File: rtl/mem_access_unit_if.sv
// Data-memory port between the MEM-stage access unit (master) and the data
// memory (slave): request/ready handshake with word address, lanes and data.
interface mem_access_unit_if #(
    parameter int WIDTH = 32
);
    logic             req;
    logic             we;
    logic [WIDTH-1:0] addr;
    logic [3:0]       be;
    logic [WIDTH-1:0] wdata;
    logic [WIDTH-1:0] rdata;
    logic             ready;

    modport master (
        output req, we, addr, be, wdata,
        input  rdata, ready
    );

    modport slave (
        input  req, we, addr, be, wdata,
        output rdata, ready
    );
endinterface

// File: rtl/mem_access_unit.sv
// MEM-stage controller: issues one request/ready transaction per load/store,
// stalls the pipeline while it is outstanding and formats load results.
module mem_access_unit #(
    parameter int WIDTH    = 32,
    parameter int MAX_WAIT = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               mem_read_mem,
    input  logic               mem_write_mem,
    input  logic               one_byte_mem,
    input  logic               two_bytes_mem,
    input  logic               four_bytes_mem,
    input  logic               load_unsigned_mem,
    input  logic [WIDTH-1:0]   alu_out_mem,
    input  logic [WIDTH-1:0]   rs2_data_mem,
    mem_access_unit_if.master  dmem,
    output logic [WIDTH-1:0]   load_data,
    output logic               mem_stall,
    output logic               misaligned,
    output logic               bus_error
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_DONE
    } state_e;

    typedef enum logic [1:0] {
        SZ_BYTE,
        SZ_HALF,
        SZ_WORD
    } size_e;

    state_e           state_q, state_d;
    logic [7:0]       cnt_q;
    logic             req_q;
    logic             we_q;
    logic [WIDTH-1:0] addr_q;
    logic [3:0]       be_q;
    logic [WIDTH-1:0] wdata_q;
    size_e            size_q;
    logic [1:0]       off_q;
    logic             uns_q;
    logic [WIDTH-1:0] load_q;
    logic             bus_err_q;

    logic             access;
    size_e            size_in;
    logic [1:0]       off_in;
    logic             mis_in;
    logic [3:0]       be_in;
    logic [WIDTH-1:0] wdata_in;
    logic [WIDTH-1:0] load_fmt;
    logic             start;
    logic             done_ok;
    logic             timeout;

    // ---------------- request decode ----------------
    assign access = mem_read_mem | mem_write_mem;
    assign off_in = alu_out_mem[1:0];

    always_comb begin
        if (four_bytes_mem)     size_in = SZ_WORD;
        else if (two_bytes_mem) size_in = SZ_HALF;
        else if (one_byte_mem)  size_in = SZ_BYTE;
        else                    size_in = SZ_WORD;
    end

    assign mis_in = ((size_in == SZ_HALF) && off_in[0]) ||
                    ((size_in == SZ_WORD) && (off_in != 2'b00));

    always_comb begin
        be_in    = 4'b1111;
        wdata_in = rs2_data_mem;
        case (size_in)
            SZ_BYTE: begin
                be_in    = 4'b0001 << off_in;
                wdata_in = {4{rs2_data_mem[7:0]}};
            end
            SZ_HALF: begin
                be_in    = off_in[1] ? 4'b1100 : 4'b0011;
                wdata_in = {2{rs2_data_mem[15:0]}};
            end
            default: begin
                be_in    = 4'b1111;
                wdata_in = rs2_data_mem;
            end
        endcase
    end

    // ---------------- load formatting ----------------
    always_comb begin
        logic [7:0]  byte_v;
        logic [15:0] half_v;
        byte_v   = 8'(dmem.rdata >> {off_q, 3'b000});
        half_v   = off_q[1] ? dmem.rdata[31:16] : dmem.rdata[15:0];
        load_fmt = dmem.rdata;
        case (size_q)
            SZ_BYTE: load_fmt = {{(WIDTH-8){~uns_q & byte_v[7]}}, byte_v};
            SZ_HALF: load_fmt = {{(WIDTH-16){~uns_q & half_v[15]}}, half_v};
            default: load_fmt = dmem.rdata;
        endcase
    end

    // ---------------- FSM next state / outputs ----------------
    // NOTE: every signal driven here gets a default first, so no path leaves
    // one unassigned and no latch is inferred.
    always_comb begin
        state_d    = state_q;
        mem_stall  = 1'b0;
        misaligned = 1'b0;
        start      = 1'b0;
        done_ok    = 1'b0;
        timeout    = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (access) begin
                    if (mis_in) begin
                        misaligned = 1'b1;
                    end else begin
                        start     = 1'b1;
                        mem_stall = 1'b1;
                        state_d   = S_WAIT;
                    end
                end
            end
            S_WAIT: begin
                mem_stall = 1'b1;
                if (dmem.ready) begin
                    done_ok = 1'b1;
                    state_d = S_DONE;
                end else if (cnt_q == 8'(MAX_WAIT - 1)) begin
                    timeout = 1'b1;
                    state_d = S_DONE;
                end
            end
            S_DONE: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
        // Reset flushes the access outright; nothing upstream may stay held.
        if (rst) begin
            mem_stall  = 1'b0;
            misaligned = 1'b0;
        end
    end

    // ---------------- registers ----------------
    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            req_q     <= 1'b0;
            we_q      <= 1'b0;
            addr_q    <= '0;
            be_q      <= '0;
            wdata_q   <= '0;
            size_q    <= SZ_WORD;
            off_q     <= '0;
            uns_q     <= 1'b0;
            load_q    <= '0;
            bus_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            bus_err_q <= 1'b0;
            if (start) begin
                cnt_q   <= '0;
                req_q   <= 1'b1;
                we_q    <= mem_write_mem;
                addr_q  <= {alu_out_mem[WIDTH-1:2], 2'b00};
                be_q    <= be_in;
                wdata_q <= wdata_in;
                size_q  <= size_in;
                off_q   <= off_in;
                uns_q   <= load_unsigned_mem;
            end
            if (state_q == S_WAIT) begin
                cnt_q <= cnt_q + 8'd1;
            end
            if (done_ok) begin
                req_q <= 1'b0;
                we_q  <= 1'b0;
                if (!we_q) begin
                    load_q <= load_fmt;
                end
            end
            if (timeout) begin
                req_q     <= 1'b0;
                we_q      <= 1'b0;
                load_q    <= '0;
                bus_err_q <= 1'b1;
            end
        end
    end

    assign dmem.req   = req_q;
    assign dmem.we    = we_q;
    assign dmem.addr  = addr_q;
    assign dmem.be    = be_q;
    assign dmem.wdata = wdata_q;

    assign load_data = misaligned ? '0 : load_q;
    assign bus_error = bus_err_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Self-checking bench for mem_access_unit: table of load/store vectors with a
// scoreboard queue, plus reset, ignored-ready and reset-mid-WAIT sequences.
module tb_mem_access_unit;

    localparam int MAX_WAIT = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        mem_read_mem, mem_write_mem;
    logic        one_byte_mem, two_bytes_mem, four_bytes_mem;
    logic        load_unsigned_mem;
    logic [31:0] alu_out_mem, rs2_data_mem;
    logic [31:0] load_data;
    logic        mem_stall, misaligned, bus_error;

    mem_access_unit_if #(.WIDTH(32)) bus ();

    mem_access_unit #(.WIDTH(32), .MAX_WAIT(MAX_WAIT)) dut (
        .clk               (clk),
        .rst               (rst),
        .mem_read_mem      (mem_read_mem),
        .mem_write_mem     (mem_write_mem),
        .one_byte_mem      (one_byte_mem),
        .two_bytes_mem     (two_bytes_mem),
        .four_bytes_mem    (four_bytes_mem),
        .load_unsigned_mem (load_unsigned_mem),
        .alu_out_mem       (alu_out_mem),
        .rs2_data_mem      (rs2_data_mem),
        .dmem              (bus),
        .load_data         (load_data),
        .mem_stall         (mem_stall),
        .misaligned        (misaligned),
        .bus_error         (bus_error)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic        wr;
        logic        rd;
        logic [2:0]  sz;      // {four, two, one}
        logic        uns;
        logic [31:0] addr;
        logic [31:0] rs2;
        logic [31:0] rdata;
        int          delay;   // WAIT cycles before ready; -1 = never
        logic        mis;
        logic [3:0]  be;
        logic [31:0] wdata;
        logic [31:0] ld;
        int          req_cycles;
        logic        berr;
    } vec_t;

    vec_t vecs[$];
    vec_t sb[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(string name, logic wr, logic rd, logic [2:0] sz, logic uns,
                                logic [31:0] addr, logic [31:0] rs2, logic [31:0] rdata,
                                int delay, logic mis, logic [3:0] be, logic [31:0] wdata,
                                logic [31:0] ld, int req_cycles, logic berr);
        vec_t v;
        v.name = name; v.wr = wr; v.rd = rd; v.sz = sz; v.uns = uns;
        v.addr = addr; v.rs2 = rs2; v.rdata = rdata; v.delay = delay;
        v.mis = mis; v.be = be; v.wdata = wdata; v.ld = ld;
        v.req_cycles = req_cycles; v.berr = berr;
        return v;
    endfunction

    task automatic clear_inputs();
        mem_read_mem      = 1'b0;
        mem_write_mem     = 1'b0;
        one_byte_mem      = 1'b0;
        two_bytes_mem     = 1'b0;
        four_bytes_mem    = 1'b0;
        load_unsigned_mem = 1'b0;
        alu_out_mem       = '0;
        rs2_data_mem      = '0;
        bus.ready         = 1'b0;
    endtask

    task automatic drive(input vec_t v);
        mem_write_mem     = v.wr;
        mem_read_mem      = v.rd;
        {four_bytes_mem, two_bytes_mem, one_byte_mem} = v.sz;
        load_unsigned_mem = v.uns;
        alu_out_mem       = v.addr;
        rs2_data_mem      = v.rs2;
        bus.rdata         = v.rdata;
        bus.ready         = 1'b0;
    endtask

    // One instruction through the MEM stage; inputs are removed in the cycle
    // the stall drops, as the pipeline would advance to a bubble.
    task automatic run_vec(input vec_t v);
        vec_t        e;
        int          stall_n, req_n;
        logic        stable, done;
        logic        c_we;
        logic [31:0] c_addr, c_wdata;
        logic [3:0]  c_be;
        sb.push_back(v);
        @(negedge clk);
        drive(v);
        #1;
        if (v.mis) begin
            e = sb.pop_front();
            check({e.name, " misaligned"}, 32'(misaligned), 32'd1);
            check({e.name, " stall"},      32'(mem_stall),  32'd0);
            check({e.name, " load_data"},  load_data,       e.ld);
        end else begin
            check({v.name, " no_misaligned"}, 32'(misaligned), 32'd0);
            stall_n = 0; req_n = 0; stable = 1'b1; done = 1'b0;
            c_we = 1'b0; c_addr = '0; c_wdata = '0; c_be = '0;
            for (int cyc = 0; cyc < 40 && !done; cyc++) begin
                if (cyc > 0) begin
                    @(negedge clk);
                    #1;
                end
                if (bus.req) begin
                    req_n++;
                    if (req_n == 1) begin
                        c_we = bus.we; c_addr = bus.addr; c_be = bus.be; c_wdata = bus.wdata;
                    end else if (c_we !== bus.we || c_addr !== bus.addr ||
                                 c_be !== bus.be || c_wdata !== bus.wdata) begin
                        stable = 1'b0;
                    end
                end
                if (mem_stall) begin
                    stall_n++;
                end else if (stall_n > 0) begin
                    done = 1'b1;
                end
                bus.ready = bus.req && (v.delay >= 0) && (req_n - 1 == v.delay);
            end
            if (!done) begin
                check({v.name, " completion"}, 32'd0, 32'd1);
                void'(sb.pop_front());
            end else begin
                e = sb.pop_front();
                check({e.name, " req_cycles"},   32'(req_n),   32'(e.req_cycles));
                check({e.name, " stall_cycles"}, 32'(stall_n), 32'(e.req_cycles + 1));
                check({e.name, " we"},           32'(c_we),    32'(e.wr));
                check({e.name, " addr"},         c_addr,       {e.addr[31:2], 2'b00});
                check({e.name, " be"},           32'(c_be),    32'(e.be));
                check({e.name, " wdata"},        c_wdata,      e.wdata);
                check({e.name, " req_stable"},   32'(stable),  32'd1);
                check({e.name, " load_data"},    load_data,    e.ld);
                check({e.name, " bus_error"},    32'(bus_error), 32'(e.berr));
            end
        end
        clear_inputs();
        @(negedge clk);
        #1;
        check({v.name, " req_after"},       32'(bus.req),   32'd0);
        check({v.name, " bus_error_after"}, 32'(bus_error), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        //          name        wr rd sz      uns addr          rs2           rdata         dly mis be       wdata         ld            req berr
        vecs.push_back(mk("lb",      0, 1, 3'b001, 0, 32'h0000_1003, 32'h0,        32'h80FF_1234, 0, 0, 4'b1000, 32'h0,        32'hFFFF_FF80, 1, 0));
        vecs.push_back(mk("sb",      1, 0, 3'b001, 0, 32'h0000_3001, 32'h1234_56AB, 32'h0,       0, 0, 4'b0010, 32'hABAB_ABAB, 32'hFFFF_FF80, 1, 0));
        vecs.push_back(mk("lhu",     0, 1, 3'b010, 1, 32'h0000_2002, 32'h0,        32'h8001_0000, 3, 0, 4'b1100, 32'h0,        32'h0000_8001, 4, 0));
        vecs.push_back(mk("sh",      1, 0, 3'b010, 0, 32'h0000_3002, 32'h0000_BEEF, 32'h0,       1, 0, 4'b1100, 32'hBEEF_BEEF, 32'h0000_8001, 2, 0));
        vecs.push_back(mk("lw_mis",  0, 1, 3'b100, 0, 32'h0000_4002, 32'h0,        32'h0,        0, 1, 4'b0000, 32'h0,        32'h0,         0, 0));
        vecs.push_back(mk("lw",      0, 1, 3'b100, 0, 32'h0000_5000, 32'h0,        32'hDEAD_BEEF, 1, 0, 4'b1111, 32'h0,        32'hDEAD_BEEF, 2, 0));
        vecs.push_back(mk("lh",      0, 1, 3'b010, 0, 32'h0000_6000, 32'h0,        32'h1234_F00D, 0, 0, 4'b0011, 32'h0,        32'hFFFF_F00D, 1, 0));
        vecs.push_back(mk("lbu",     0, 1, 3'b001, 1, 32'h0000_7002, 32'h0,        32'h0055_AA00, 2, 0, 4'b0100, 32'h0,        32'h0000_0055, 3, 0));
        vecs.push_back(mk("lb_b1",   0, 1, 3'b001, 0, 32'h0000_7001, 32'h0,        32'h0055_AA00, 0, 0, 4'b0010, 32'h0,        32'hFFFF_FFAA, 1, 0));
        vecs.push_back(mk("l_nosz",  0, 1, 3'b000, 0, 32'h0000_9000, 32'h0,        32'h1122_3344, 0, 0, 4'b1111, 32'h0,        32'h1122_3344, 1, 0));
        vecs.push_back(mk("lh_mis",  0, 1, 3'b010, 0, 32'h0000_A001, 32'h0,        32'h0,        0, 1, 4'b0000, 32'h0,        32'h0,         0, 0));
        vecs.push_back(mk("prio_w",  0, 1, 3'b111, 0, 32'h0000_B001, 32'h0,        32'h0,        0, 1, 4'b0000, 32'h0,        32'h0,         0, 0));
        vecs.push_back(mk("prio_h",  0, 1, 3'b011, 0, 32'h0000_B001, 32'h0,        32'h0,        0, 1, 4'b0000, 32'h0,        32'h0,         0, 0));
        vecs.push_back(mk("st_prio", 1, 1, 3'b011, 0, 32'h0000_B002, 32'h0000_1357, 32'h0,       0, 0, 4'b1100, 32'h1357_1357, 32'h1122_3344, 1, 0));
        vecs.push_back(mk("sw_mis",  1, 0, 3'b100, 0, 32'h0000_D001, 32'h1111_1111, 32'h0,       0, 1, 4'b0000, 32'h0,        32'h0,         0, 0));
        vecs.push_back(mk("timeout", 0, 1, 3'b100, 0, 32'h0000_C000, 32'h0,        32'h5555_5555, -1, 0, 4'b1111, 32'h0,       32'h0,         MAX_WAIT, 1));
        vecs.push_back(mk("sw",      1, 0, 3'b100, 0, 32'h0000_8000, 32'hCAFE_F00D, 32'h0,       0, 0, 4'b1111, 32'hCAFE_F00D, 32'h0,         1, 0));
        vecs.push_back(mk("lbu_b0",  0, 1, 3'b001, 1, 32'h0000_1000, 32'h0,        32'h0000_00FF, 0, 0, 4'b0001, 32'h0,        32'h0000_00FF, 1, 0));

        clear_inputs();
        bus.rdata = '0;
        rst = 1'b1;
        #3;
        check("rst req",       32'(bus.req),   32'd0);
        check("rst we",        32'(bus.we),    32'd0);
        check("rst addr",      bus.addr,       32'd0);
        check("rst be",        32'(bus.be),    32'd0);
        check("rst wdata",     bus.wdata,      32'd0);
        check("rst load_data", load_data,      32'd0);
        check("rst bus_error", 32'(bus_error), 32'd0);
        check("rst stall",     32'(mem_stall), 32'd0);
        check("rst misaligned", 32'(misaligned), 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;

        foreach (vecs[i]) run_vec(vecs[i]);

        // Ready outside WAIT must not start or complete anything.
        @(negedge clk);
        bus.ready = 1'b1;
        bus.rdata = 32'h7777_7777;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            #1;
            check("ign_ready req",   32'(bus.req),   32'd0);
            check("ign_ready stall", 32'(mem_stall), 32'd0);
            check("ign_ready load",  load_data,      32'h0000_00FF);
        end
        bus.ready = 1'b0;

        // Async reset while a load waits for ready.
        @(negedge clk);
        drive(mk("rst_lw", 0, 1, 3'b100, 0, 32'h0000_E000, 32'h0, 32'h0, 0, 0, 4'b1111, 32'h0, 32'h0, 1, 0));
        @(negedge clk);
        #1;
        check("rst_wait in_wait req", 32'(bus.req), 32'd1);
        #1;
        rst = 1'b1;
        #1;
        check("rst_wait req",   32'(bus.req),   32'd0);
        check("rst_wait stall", 32'(mem_stall), 32'd0);
        clear_inputs();
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("rst_wait load_data", load_data, 32'd0);
        run_vec(mk("post_rst", 0, 1, 3'b100, 0, 32'h0000_E000, 32'h0, 32'h0BAD_F00D, 0, 0, 4'b1111, 32'h0, 32'h0BAD_F00D, 1, 0));

        check("scoreboard empty", 32'(sb.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/mem_access_unit.md
# mem_access_unit

- Memory-stage controller of the multicycle RISC-V pipeline, between the EX/MEM pipeline register and the MEM/WB register.
- Turns the MEM-stage control bits (read/write, access size, signedness) plus address and store data into a request/ready transaction on the data-memory port. Byte lanes are aligned for stores; load results are extracted and extended.
- Holds the pipeline through `mem_stall` while a transaction is outstanding. Reports misaligned accesses and bus timeouts.

## Interface

- `WIDTH`, 32: data/address width; block supports only 32.
- `MAX_WAIT`, 16: wait cycles allowed for `dmem_ready` before timeout (1..255).

- `clk` input 1: clock, rising edge.
- `rst` input 1: reset, asynchronous, active-high.
- `mem_read_mem` input 1: load in MEM stage.
- `mem_write_mem` input 1: store in MEM stage; has priority if both are set.
- `one_byte_mem`, `two_bytes_mem`, `four_bytes_mem` input 1 each: access size.
- `load_unsigned_mem` input 1: zero-extend the load (LBU/LHU).
- `alu_out_mem` input WIDTH: byte address.
- `rs2_data_mem` input WIDTH: store data (LSBs).
- `dmem_req` output 1: bus request.
- `dmem_we` output 1: write strobe, valid with `dmem_req`.
- `dmem_addr` output WIDTH: word-aligned address (`[1:0]=0`).
- `dmem_be` output 4: byte enables.
- `dmem_wdata` output WIDTH: lane-replicated store data.
- `dmem_rdata` input WIDTH: read word, valid when `dmem_ready`.
- `dmem_ready` input 1: transaction complete this cycle.
- `load_data` output WIDTH: formatted load result to MEM/WB.
- `mem_stall` output 1: holds PC/IF/ID/EX/MEM registers (`en` low).
- `misaligned` output 1: misaligned-access flag.
- `bus_error` output 1: timeout pulse.

## Operation

- **Access size:** `four_bytes` wins over `two_bytes`, which wins over `one_byte`. If no size bit is set, the access is a word.
- **Misalignment:** a half access with `addr[0]=1` is misaligned. A word access with `addr[1:0]!=0` is misaligned.
- **States:** IDLE, WAIT, DONE.
- **IDLE, aligned access present:**
  - Register `dmem_addr = {addr[31:2],2'b00}`, `dmem_be`, `dmem_wdata`, `dmem_we`, and the size/offset/unsigned attributes.
  - Go to WAIT.
  - `mem_stall=1`, combinational.
- **IDLE, misaligned access:**
  - `misaligned=1` combinationally.
  - No request is issued, `mem_stall=0`, and `load_data` is forced to 0.
- **WAIT:**
  - `dmem_req=1`, `mem_stall=1`, and the wait counter increments.
  - On `dmem_ready`, a load registers the formatted `dmem_rdata` into `load_data`. Then go to DONE.
  - When the counter reaches `MAX_WAIT` with no ready: drop the request, set `load_data=0`, set `bus_error=1` (registered), and go to DONE.
- **DONE:**
  - `dmem_req=0` and `mem_stall=0`, so MEM/WB captures `load_data`.
  - `bus_error` is clear again on the next cycle.
  - Go to IDLE unconditionally. IDLE evaluates the next instruction one cycle later.
- **Store lanes**, with `o = addr[1:0]`:
  - byte: `be = 4'b0001<<o`, `wdata = {4{rs2[7:0]}}`.
  - half: `be = o[1] ? 1100 : 0011`, `wdata = {2{rs2[15:0]}}`.
  - word: `be = 1111`, `wdata = rs2`.
- **Load formatting:**
  - byte = `rdata[8*o +: 8]`.
  - half = `rdata[16*o[1] +: 16]`.
  - Sign-extended unless `load_unsigned`. Word loads pass through.
- **Stores:** `load_data` holds its previous value.

## Timing

- **Reset values:** state IDLE; counter, `dmem_req`, `dmem_we`, `dmem_addr`, `dmem_be`, `dmem_wdata`, `load_data` and `bus_error` are all 0. `mem_stall` and `misaligned` are 0 because they are decoded from IDLE with no access present.
- **Latency:** minimum access is 3 cycles (IDLE, WAIT with same-cycle ready, DONE). Each additional wait cycle adds 1.
- **Bus protocol:** the request is held stable from entry into WAIT until the ready cycle. `dmem_req` deasserts in the cycle after `dmem_ready`.
- **Timeout:** WAIT is left after exactly `MAX_WAIT` cycles if ready never arrives. Ready in the same cycle as the timeout counts as success.
- **Ignored ready:** `dmem_ready` outside WAIT is ignored.
- **Reset mid-transaction:** async `rst` returns to IDLE immediately and `dmem_req` drops without waiting for ready.
- **Upstream flush:** an EX/MEM flush while in WAIT or DONE does not abort the issued access. The transaction completes.

## Test plan

- **Signed byte load:** LB at `0x1003`, `rdata=0x80FF_1234` with ready in the first WAIT cycle → `load_data=0xFFFF_FF80`. `mem_stall` is high for 2 cycles, `dmem_addr=0x1000`.
- **Unsigned half load:** LHU at `0x2002`, `rdata=0x8001_0000`, ready after 3 wait cycles → `load_data=0x0000_8001`. Stall lasts 5 cycles.
- **Byte store:** SB of `rs2=0x1234_56AB` to `0x3001` → `dmem_we=1`, `dmem_be=0010`, `dmem_wdata=0xABAB_ABAB`.
- **Half store:** SH of `0xBEEF` to `0x3002` → `dmem_be=1100`, `dmem_wdata=0xBEEF_BEEF`.
- **Misaligned word load:** LW at `0x4002` → `misaligned=1`, no `dmem_req`, no stall, `load_data=0`.
- **Timeout:** `MAX_WAIT=4`, ready never asserted → `dmem_req` is high for exactly 4 cycles, then a 1-cycle `bus_error` pulse, `load_data=0`.
- **Reset mid-WAIT:** assert `rst` during WAIT → `dmem_req` and `mem_stall` are 0 at once. The next load after reset completes normally.
